encoder_menu_ctrl: RTL and testbench

ENCODER_MENU_CTRL -- requirements
Module: encoder_menu_ctrl

---
 rtl/menu_pkg.sv | 15 +
 rtl/menu_timeout.sv | 39 +++
 rtl/encoder_menu_ctrl.sv | 102 ++++++++++
 tb/tb_encoder_menu_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared menu state encoding and default build constants for the encoder menu.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_EDIT   = 2'd2
  } menu_state_e;

  localparam int DEF_N_ITEMS   = 4;
  localparam int DEF_PW        = 4;
  localparam int DEF_TIMEOUT_S = 10;
  localparam int TMO_W         = 8;

endpackage

// File: rtl/menu_timeout.sv
// Inactivity counter: counts idle sec_tick strobes while enabled, flags expiry at TIMEOUT_S.
module menu_timeout
  import menu_pkg::*;
#(
  parameter int TIMEOUT_S = DEF_TIMEOUT_S
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic activity,
  input  logic sec_tick,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_S);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Expiry forces the menu to IDLE on the same edge, so the counter restarts from 0 there.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || activity || (cnt_q == LIMIT)) begin
      cnt_d = '0;
    end else if (sec_tick) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/encoder_menu_ctrl.sv
// Rotary-encoder menu: browse items, edit a shadow copy, commit on button, drop to IDLE on inactivity.
module encoder_menu_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS   = DEF_N_ITEMS,
  parameter int PW        = DEF_PW,
  parameter int TIMEOUT_S = DEF_TIMEOUT_S,
  localparam int SW       = $clog2(N_ITEMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_tick,
  input  logic                  l_tick,
  input  logic                  btn_tick,
  input  logic                  sec_tick,
  output logic [1:0]            state,
  output logic [SW-1:0]         sel,
  output logic [PW-1:0]         edit_val,
  output logic [N_ITEMS*PW-1:0] params,
  output logic                  commit,
  output logic [SW-1:0]         commit_idx
);

  menu_state_e           state_q;
  logic [SW-1:0]         sel_q;
  logic [PW-1:0]         shadow_q;
  logic [N_ITEMS*PW-1:0] params_q;
  logic                  commit_q;
  logic [SW-1:0]         commit_idx_q;

  logic rot_r, rot_l, activity, expired;

  // Opposite detents in one cycle cancel out entirely.
  assign rot_r    = r_tick & ~l_tick;
  assign rot_l    = l_tick & ~r_tick;
  assign activity = btn_tick | rot_r | rot_l;

  menu_timeout #(
    .TIMEOUT_S(TIMEOUT_S)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != ST_IDLE),
    .activity(activity),
    .sec_tick(sec_tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      shadow_q     <= '0;
      params_q     <= '0;
      commit_q     <= 1'b0;
      commit_idx_q <= '0;
    end else begin
      commit_q <= 1'b0;
      if (expired) begin
        state_q  <= ST_IDLE;
        shadow_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (btn_tick) state_q <= ST_BROWSE;
          end
          ST_BROWSE: begin
            if (btn_tick) begin
              state_q  <= ST_EDIT;
              shadow_q <= params_q[sel_q*PW +: PW];
            end else if (rot_r) begin
              sel_q <= sel_q + SW'(1);
            end else if (rot_l) begin
              sel_q <= sel_q - SW'(1);
            end
          end
          ST_EDIT: begin
            if (btn_tick) begin
              params_q[sel_q*PW +: PW] <= shadow_q;
              commit_q                 <= 1'b1;
              commit_idx_q             <= sel_q;
              state_q                  <= ST_BROWSE;
            end else if (rot_r && (shadow_q != {PW{1'b1}})) begin
              shadow_q <= shadow_q + PW'(1);
            end else if (rot_l && (shadow_q != '0)) begin
              shadow_q <= shadow_q - PW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign state      = state_q;
  assign sel        = sel_q;
  assign edit_val   = (state_q == ST_EDIT) ? shadow_q : params_q[sel_q*PW +: PW];
  assign params     = params_q;
  assign commit     = commit_q;
  assign commit_idx = commit_idx_q;

endmodule

// File: tb/tb_encoder_menu_ctrl.sv
// Directed bench for encoder_menu_ctrl: snapshot and commit scoreboards fed by the driver, drained by monitors.
module tb_encoder_menu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_tick, l_tick, btn_tick, sec_tick;
  logic [1:0]  state;
  logic [1:0]  sel;
  logic [3:0]  edit_val;
  logic [15:0] params;
  logic        commit;
  logic [1:0]  commit_idx;

  int checks = 0;
  int errors = 0;

  // snapshot = {state, sel, edit_val, params, commit}
  logic [24:0] exp_q[$];
  string       name_q[$];
  // commit record = {commit_idx, params}
  logic [17:0] cexp_q[$];

  encoder_menu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .r_tick    (r_tick),
    .l_tick    (l_tick),
    .btn_tick  (btn_tick),
    .sec_tick  (sec_tick),
    .state     (state),
    .sel       (sel),
    .edit_val  (edit_val),
    .params    (params),
    .commit    (commit),
    .commit_idx(commit_idx)
  );

  always #5 clk = ~clk;

  // Snapshot monitor: compares every pending expectation at the falling edge.
  always @(negedge clk) begin
    logic [24:0] e, a;
    string nm;
    a = {state, sel, edit_val, params, commit};
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sel=%0d ev=%0d params=%h commit=%b, want st=%0d sel=%0d ev=%0d params=%h commit=%b",
                 nm, a[24:23], a[22:21], a[20:17], a[16:1], a[0],
                 e[24:23], e[22:21], e[20:17], e[16:1], e[0]);
      end
    end
  end

  // Commit monitor: every commit pulse must match the next expected write.
  always @(negedge clk) begin
    logic [17:0] c;
    if (commit === 1'b1) begin
      checks++;
      if (cexp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got idx=%0d params=%h, want no commit", commit_idx, params);
      end else begin
        c = cexp_q.pop_front();
        if ({commit_idx, params} !== c) begin
          errors++;
          $display("FAIL commit_data: got idx=%0d params=%h, want idx=%0d params=%h",
                   commit_idx, params, c[17:16], c[15:0]);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input logic b, input logic s);
    @(posedge clk); #1;
    r_tick = r; l_tick = l; btn_tick = b; sec_tick = s;
  endtask

  task automatic pulse(input int n, input logic r, input logic l, input logic b, input logic s);
    for (int i = 0; i < n; i++) begin
      cyc(r, l, b, s);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_snap(input string nm, input logic [1:0] st, input logic [1:0] sl,
                             input logic [3:0] ev, input logic [15:0] pr, input logic cm);
    exp_q.push_back({st, sl, ev, pr, cm});
    name_q.push_back(nm);
  endtask

  task automatic expect_commit(input logic [1:0] idx, input logic [15:0] pr);
    cexp_q.push_back({idx, pr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; r_tick = 1'b0; l_tick = 1'b0; btn_tick = 1'b0; sec_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_snap("reset", 2'd0, 2'd0, 4'd0, 16'h0000, 1'b0);

    // IDLE ignores rotation, button enters BROWSE, sel wraps both ways
    pulse(2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("idle_rot_ignored", 2'd0, 2'd0, 4'd0, 16'h0000, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_snap("enter_browse", 2'd1, 2'd0, 4'd0, 16'h0000, 1'b0);
    pulse(4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("sel_wrap_up", 2'd1, 2'd0, 4'd0, 16'h0000, 1'b0);
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("sel_after_5r", 2'd1, 2'd1, 4'd0, 16'h0000, 1'b0);
    pulse(2, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_snap("sel_wrap_down", 2'd1, 2'd3, 4'd0, 16'h0000, 1'b0);
    pulse(3, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("sel_to_2", 2'd1, 2'd2, 4'd0, 16'h0000, 1'b0);

    // Edit item 2 to saturation and commit
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_snap("enter_edit_2", 2'd2, 2'd2, 4'd0, 16'h0000, 1'b0);
    pulse(15, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("shadow_15", 2'd2, 2'd2, 4'd15, 16'h0000, 1'b0);
    pulse(5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("shadow_sat_hi", 2'd2, 2'd2, 4'd15, 16'h0000, 1'b0);
    expect_commit(2'd2, 16'h0F00);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_snap("commit_2_pulse", 2'd1, 2'd2, 4'd15, 16'h0F00, 1'b1);
    idle(1);
    expect_snap("commit_2_one_cycle", 2'd1, 2'd2, 4'd15, 16'h0F00, 1'b0);

    // Item 0: low saturation, cancelled rotation does not clear the timer
    pulse(2, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_snap("browse_item0", 2'd1, 2'd0, 4'd0, 16'h0F00, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(3, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_snap("shadow_sat_lo", 2'd2, 2'd0, 4'd0, 16'h0F00, 1'b0);
    pulse(1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_snap("r_and_l_no_change", 2'd2, 2'd0, 4'd0, 16'h0F00, 1'b0);
    pulse(9, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_snap("r_and_l_no_activity", 2'd2, 2'd0, 4'd0, 16'h0F00, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_snap("edit_timeout_item0", 2'd0, 2'd0, 4'd0, 16'h0F00, 1'b0);

    // BROWSE timeout, then activity on the 10th strobe keeps BROWSE
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(10, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_snap("browse_timeout", 2'd0, 2'd0, 4'd0, 16'h0F00, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(9, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_snap("activity_beats_timeout", 2'd1, 2'd1, 4'd0, 16'h0F00, 1'b0);
    pulse(9, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_snap("counter_restarted", 2'd1, 2'd1, 4'd0, 16'h0F00, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_snap("browse_timeout_2", 2'd0, 2'd1, 4'd0, 16'h0F00, 1'b0);

    // EDIT item 1 to 7, timeout discards the shadow
    pulse(2, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("shadow_7", 2'd2, 2'd1, 4'd7, 16'h0F00, 1'b0);
    pulse(10, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_snap("edit_timeout_no_commit", 2'd0, 2'd1, 4'd0, 16'h0F00, 1'b0);
    pulse(2, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_snap("shadow_reloaded", 2'd2, 2'd1, 4'd0, 16'h0F00, 1'b0);

    // Commit 2 into item 1, then button+rotation, then reset mid-EDIT
    pulse(2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_commit(2'd1, 16'h0F20);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_snap("commit_1_pulse", 2'd1, 2'd1, 4'd2, 16'h0F20, 1'b1);
    pulse(1, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_snap("btn_beats_rot", 2'd2, 2'd1, 4'd2, 16'h0F20, 1'b0);
    pulse(3, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_snap("shadow_5", 2'd2, 2'd1, 4'd5, 16'h0F20, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    expect_snap("reset_mid_edit", 2'd0, 2'd0, 4'd0, 16'h0000, 1'b0);
    idle(2);
    expect_snap("after_reset_idle", 2'd0, 2'd0, 4'd0, 16'h0000, 1'b0);

    idle(4);
    checks++;
    if (cexp_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got commit_left=%0d snap_left=%0d, want 0 and 0",
               cexp_q.size(), exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
